// File: rtl/tob_msg_tx.sv
// tob_msg_tx -- top-of-book message transmitter.
//
// Takes best-bid/best-ask snapshots from the order book and drops any
// snapshot identical to the last one accepted. Each accepted snapshot goes
// into a single pending slot, where a newer snapshot replaces an older one.
// The pending snapshot is serialised MSB byte first onto a byte-wide
// valid/ready stream as one fixed-length message:
//   MSG_TYPE, locate[15:0], bid price, bid shares, ask price, ask shares
//   [, sequence[31:0]]
//
// Build option:
//   TOB_TX_SEQ_EN  when defined, a 32-bit sequence field is appended
//                  (23-byte message). Otherwise the message is 19 bytes.
//
// Ports:
//   clkIn            clock, rising edge
//   rstIn            asynchronous active-high reset
//   snapValidIn      one-cycle snapshot strobe
//   snapLocateIn     instrument locate (16)
//   bidPriceIn       best buy price (32)
//   bidSharesIn      best buy quantity (32)
//   askPriceIn       best sell price (32)
//   askSharesIn      best sell quantity (32)
//   txDataOut        message byte (8)
//   txValidOut       txDataOut valid
//   txLastOut        final byte of message, qualified by txValidOut
//   txReadyIn        downstream accept
//   busyOut          message in flight or pending
//   overwriteCntOut  pending snapshots overwritten before sending, saturating (16)

module tob_msg_tx #(
    parameter logic [7:0] MSG_TYPE = 8'h51
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        snapValidIn,
    input  logic [15:0] snapLocateIn,
    input  logic [31:0] bidPriceIn,
    input  logic [31:0] bidSharesIn,
    input  logic [31:0] askPriceIn,
    input  logic [31:0] askSharesIn,
    output logic [7:0]  txDataOut,
    output logic        txValidOut,
    output logic        txLastOut,
    input  logic        txReadyIn,
    output logic        busyOut,
    output logic [15:0] overwriteCntOut
);

`ifdef TOB_TX_SEQ_EN
    localparam int MSG_BYTES = 23;
`else
    localparam int MSG_BYTES = 19;
`endif
    localparam int         MSG_BITS = MSG_BYTES * 8;
    localparam logic [4:0] LAST_IDX = 5'(MSG_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state;
    logic [143:0]          snap;
    logic [143:0]          last_snap;
    logic [143:0]          pend_snap;
    logic                  last_valid;
    logic                  pending;
    logic                  accept;
    logic                  load;
    logic [MSG_BITS-1:0]   shreg;
    logic [4:0]            byte_cnt;
    logic                  tx_valid;
    logic                  tx_last;
    logic [15:0]           overwrite_cnt;
`ifdef TOB_TX_SEQ_EN
    logic [31:0]           seq;
`endif

    assign snap   = {snapLocateIn, bidPriceIn, bidSharesIn, askPriceIn, askSharesIn};
    // Before the first acceptance after reset there is no reference snapshot,
    // so anything (including all zeros) is accepted.
    assign accept = snapValidIn && (!last_valid || (snap != last_snap));
    assign load   = (state == IDLE) && pending;

    // Capture side: filter duplicates and keep the newest snapshot pending.
    // When a load happens in the same cycle as an acceptance, the load takes
    // the old slot content, so the new snapshot is not counted as an overwrite.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            last_snap     <= '0;
            last_valid    <= 1'b0;
            pend_snap     <= '0;
            pending       <= 1'b0;
            overwrite_cnt <= '0;
        end else begin
            if (accept) begin
                last_snap  <= snap;
                last_valid <= 1'b1;
                pend_snap  <= snap;
                pending    <= 1'b1;
                if (pending && !load && (overwrite_cnt != 16'hFFFF)) begin
                    overwrite_cnt <= overwrite_cnt + 16'd1;
                end
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    // Transmit FSM. The shift register's top byte is the current output byte;
    // after the final shift it is all zeros, so txDataOut idles at zero.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
`ifdef TOB_TX_SEQ_EN
            seq      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
`ifdef TOB_TX_SEQ_EN
                        shreg <= {MSG_TYPE, pend_snap, seq + 32'd1};
                        seq   <= seq + 32'd1;
`else
                        shreg <= {MSG_TYPE, pend_snap};
`endif
                        byte_cnt <= '0;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (txReadyIn) begin
                        shreg <= {shreg[MSG_BITS-9:0], 8'h00};
                        if (byte_cnt == LAST_IDX) begin
                            byte_cnt <= '0;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            tx_last  <= ((byte_cnt + 5'd1) == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign txDataOut       = shreg[MSG_BITS-1 -: 8];
    assign txValidOut      = tx_valid;
    assign txLastOut       = tx_last;
    assign busyOut         = pending || (state == SEND);
    assign overwriteCntOut = overwrite_cnt;

endmodule

// File: tb/tb_tob_msg_tx.sv
// tb_tob_msg_tx -- self-checking bench for tob_msg_tx.
//
// A behavioural model tracks the last accepted snapshot, the single pending
// slot, the number of bytes left in the message on the wire and the sequence
// number. It builds each expected message as a byte array when the
// transmitter would pick up the pending snapshot. Outputs are checked 1 time
// unit after every rising edge.
//
// Build option TOB_TX_SEQ_EN selects the 23-byte message with sequence field.

module tb_tob_msg_tx;

`ifdef TOB_TX_SEQ_EN
    localparam int LEN = 23;
`else
    localparam int LEN = 19;
`endif

    logic        clkIn;
    logic        rstIn;
    logic        snapValidIn;
    logic [15:0] snapLocateIn;
    logic [31:0] bidPriceIn;
    logic [31:0] bidSharesIn;
    logic [31:0] askPriceIn;
    logic [31:0] askSharesIn;
    logic [7:0]  txDataOut;
    logic        txValidOut;
    logic        txLastOut;
    logic        txReadyIn;
    logic        busyOut;
    logic [15:0] overwriteCntOut;

    tob_msg_tx dut (
        .clkIn          (clkIn),
        .rstIn          (rstIn),
        .snapValidIn    (snapValidIn),
        .snapLocateIn   (snapLocateIn),
        .bidPriceIn     (bidPriceIn),
        .bidSharesIn    (bidSharesIn),
        .askPriceIn     (askPriceIn),
        .askSharesIn    (askSharesIn),
        .txDataOut      (txDataOut),
        .txValidOut     (txValidOut),
        .txLastOut      (txLastOut),
        .txReadyIn      (txReadyIn),
        .busyOut        (busyOut),
        .overwriteCntOut(overwriteCntOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    int total;
    int bad;
    int dut_msgs;

    // Model state
    logic [143:0] m_last;
    logic [143:0] m_pend;
    bit           m_have_last;
    bit           m_pending;
    int           bytes_left;
    int           m_ovf;
    logic [31:0]  m_seq;
    logic [7:0]   cur_msg [LEN];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last      = '0;
        m_pend      = '0;
        m_have_last = 0;
        m_pending   = 0;
        bytes_left  = 0;
        m_ovf       = 0;
        m_seq       = '0;
    endtask

    // Called right after a rising edge, with the inputs that edge sampled.
    task automatic model_edge();
        logic [143:0] s;
        logic [175:0] body;
        bit           acc;
        bit           do_load;
        s       = {snapLocateIn, bidPriceIn, bidSharesIn, askPriceIn, askSharesIn};
        acc     = snapValidIn && (!m_have_last || (s != m_last));
        do_load = (bytes_left == 0) && m_pending;
        if (do_load) begin
            m_seq   = m_seq + 32'd1;
            body    = '0;
`ifdef TOB_TX_SEQ_EN
            body    = {m_pend, m_seq};
`else
            body[143:0] = m_pend;
`endif
            cur_msg[0] = 8'h51;
            for (int i = 1; i < LEN; i++) begin
                cur_msg[i] = 8'(body >> (8 * (LEN - 1 - i)));
            end
            bytes_left = LEN;
        end else if ((bytes_left > 0) && txReadyIn) begin
            bytes_left--;
        end
        if (acc) begin
            if (m_pending && !do_load && (m_ovf < 65535)) m_ovf++;
            m_pend      = s;
            m_pending   = 1;
            m_last      = s;
            m_have_last = 1;
        end else if (do_load) begin
            m_pending = 0;
        end
    endtask

    task automatic check_output();
        check_value("valid", 32'(txValidOut), 32'(bytes_left > 0));
        check_value("last", 32'(txLastOut), 32'(bytes_left == 1));
        check_value("busy", 32'(busyOut), 32'(m_pending || (bytes_left > 0)));
        check_value("ovf", 32'(overwriteCntOut), 32'(m_ovf));
        if (bytes_left > 0) begin
            check_value("data", 32'(txDataOut), 32'(cur_msg[LEN - bytes_left]));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check.
    task automatic apply_stimulus(input bit v, input logic [143:0] s, input bit rdy);
        {snapLocateIn, bidPriceIn, bidSharesIn, askPriceIn, askSharesIn} = s;
        snapValidIn = v;
        txReadyIn   = rdy;
        if (txValidOut && txReadyIn && txLastOut) dut_msgs++;
        @(posedge clkIn);
        model_edge();
        #1;
        check_output();
        snapValidIn = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_pending || (bytes_left > 0)) && (n < 300)) begin
            apply_stimulus(0, '0, 1);
            n++;
        end
        if (n >= 300) check_value("drain_timeout", 32'(busyOut), 32'd0);
        apply_stimulus(0, '0, 1);
    endtask

    logic [143:0] s1, s2, s3, s4, sa, sb, sc, s5;
    logic [143:0] pool [4];
    logic [7:0]   exp1 [23];
    int           msgs_before;
    int           ovf_before;
    int           guard;

    initial begin
        total = 0;
        bad = 0;
        dut_msgs = 0;
        model_reset();
        snapValidIn = 0;
        txReadyIn = 1;
        {snapLocateIn, bidPriceIn, bidSharesIn, askPriceIn, askSharesIn} = '0;
        exp1 = '{8'h51, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h01, 8'hF4,
                 8'h00, 8'h00, 8'h00, 8'h65, 8'h00, 8'h00, 8'h01, 8'h2C,
                 8'h00, 8'h00, 8'h00, 8'h01};

        // Reset state
        rstIn = 1'b1;
        repeat (2) @(posedge clkIn);
        #1;
        check_value("rst_data", 32'(txDataOut), 32'd0);
        check_value("rst_valid", 32'(txValidOut), 32'd0);
        check_value("rst_last", 32'(txLastOut), 32'd0);
        check_value("rst_busy", 32'(busyOut), 32'd0);
        check_value("rst_ovf", 32'(overwriteCntOut), 32'd0);
        @(negedge clkIn);
        rstIn = 1'b0;

        // Single snapshot: latency and exact byte stream
        $display("[TB] single snapshot");
        s1 = {16'h0007, 32'd100, 32'd500, 32'd101, 32'd300};
        apply_stimulus(1, s1, 1);
        check_value("lat_n1_valid", 32'(txValidOut), 32'd0);
        apply_stimulus(0, s1, 1);
        check_value("lat_n2_valid", 32'(txValidOut), 32'd1);
        for (int k = 0; k < LEN; k++) begin
            check_value($sformatf("s1_byte%0d", k), 32'(txDataOut), 32'(exp1[k]));
            check_value($sformatf("s1_last%0d", k), 32'(txLastOut), 32'(k == LEN - 1));
            apply_stimulus(0, s1, 1);
        end
        drain();

        // Same snapshot three times gives one message
        $display("[TB] duplicate suppression");
        s2 = {16'h0100, 32'hDEAD0001, 32'd42, 32'hDEAD0002, 32'd43};
        msgs_before = dut_msgs;
        repeat (3) apply_stimulus(1, s2, 1);
        drain();
        check_value("dup_msgs", 32'(dut_msgs - msgs_before), 32'd1);
        check_value("dup_ovf", 32'(overwriteCntOut), 32'd0);

        // Backpressure pattern 1,0,0,1
        $display("[TB] backpressure");
        s3 = {16'h0A0B, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        msgs_before = dut_msgs;
        apply_stimulus(1, s3, 1);
        guard = 0;
        while ((m_pending || (bytes_left > 0)) && (guard < 400)) begin
            apply_stimulus(0, s3, (guard % 4 == 0) || (guard % 4 == 3));
            guard++;
        end
        if (guard >= 400) check_value("bp_timeout", 32'(busyOut), 32'd0);
        drain();
        check_value("bp_msgs", 32'(dut_msgs - msgs_before), 32'd1);

        // A, B, C on consecutive cycles around the end of a message
        $display("[TB] latest wins");
        s4 = {16'h0004, 32'd1, 32'd2, 32'd3, 32'd4};
        sa = {16'h000A, 32'd10, 32'd11, 32'd12, 32'd13};
        sb = {16'h000B, 32'd20, 32'd21, 32'd22, 32'd23};
        sc = {16'h000C, 32'd30, 32'd31, 32'd32, 32'd33};
        ovf_before = m_ovf;
        apply_stimulus(1, s4, 1);
        guard = 0;
        while ((bytes_left != 1) && (guard < 100)) begin
            apply_stimulus(0, s4, 1);
            guard++;
        end
        apply_stimulus(1, sa, 1);
        apply_stimulus(1, sb, 1);
        apply_stimulus(1, sc, 1);
        check_value("abc_ovf", 32'(overwriteCntOut), 32'(ovf_before + 1));
        drain();

`ifdef TOB_TX_SEQ_EN
        // Sequence wrap
        $display("[TB] sequence wrap");
        force dut.seq = 32'hFFFFFFFE;
        @(negedge clkIn);
        release dut.seq;
        m_seq = 32'hFFFFFFFE;
        apply_stimulus(1, s1, 1);
        drain();
        apply_stimulus(1, s2, 1);
        drain();
        check_value("wrap_seq", 32'(m_seq), 32'(dut.seq));
`endif

        // Reset in the middle of a message
        $display("[TB] reset mid-message");
        s5 = {16'h5555, 32'd7, 32'd8, 32'd9, 32'd10};
        apply_stimulus(1, s5, 1);
        guard = 0;
        while ((bytes_left != LEN - 10) && (guard < 100)) begin
            apply_stimulus(0, s5, 1);
            guard++;
        end
        #2;
        rstIn = 1'b1;
        #1;
        check_value("mid_rst_valid", 32'(txValidOut), 32'd0);
        check_value("mid_rst_last", 32'(txLastOut), 32'd0);
        check_value("mid_rst_busy", 32'(busyOut), 32'd0);
        model_reset();
        @(negedge clkIn);
        rstIn = 1'b0;
        apply_stimulus(1, s5, 1);
        drain();

        // Randomised traffic from a small pool so duplicates occur
        $display("[TB] random traffic");
        for (int i = 0; i < 4; i++) begin
            pool[i] = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
        end
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 3) == 0, pool[$urandom_range(0, 3)],
                           $urandom_range(0, 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
